// File: rtl/cpu_arb_pkg.sv
// Shared constants for the CPU instruction/data SRAM arbiter.
package cpu_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_CNT_W   = 4;

  // Response tracker: which master gets data_ok in the current cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } trk_state_e;

  // Current owner of the SRAM request port
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/cpu_arb_resp_tracker.sv
// Tracks which master owns the SRAM read data one cycle after a grant and
// steers data_ok/rdata to that master only.
module cpu_arb_resp_tracker
  import cpu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              grant_i,
  input  logic              grant_d,
  input  logic              grant_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata
);

  trk_state_e state;
  trk_state_e state_nxt;
  logic       wr_q;

  // State register and store flag of the access now in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      wr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_q  <= grant_d & grant_wr;
    end
  end

  // Next state from this cycle's grant; responses decoded from current state
  always_comb begin
    state_nxt    = IDLE;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (grant_i) begin
      state_nxt = RESP_I;
    end else if (grant_d) begin
      state_nxt = RESP_D;
    end
    case (state)
      RESP_I: begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_rdata;
      end
      RESP_D: begin
        data_data_ok = 1'b1;
        data_rdata   = wr_q ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates a single-ported SRAM between CPU fetch and load/store ports.
// Data has priority; a saturating starvation counter forces one inst grant.
// Optional macro CPU_ARB_PERF_CNT_EN adds three free-running perf counters.
module cpu_mem_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  input  logic [DATA_W-1:0]   mem_rdata,
`ifdef CPU_ARB_PERF_CNT_EN
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_inst_stall_cnt,
  output logic [31:0]         perf_force_cnt,
`endif
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    inst_live;
  logic                    data_live;
  logic                    force_inst;
  logic                    grant_i;
  logic                    grant_d;
  owner_e                  owner;

  // Grant decision; requests are masked while reset is held
  always_comb begin
    inst_live  = inst_req & resetn;
    data_live  = data_req & resetn;
    force_inst = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    owner      = OWN_DATA;
    if (inst_live && (!data_live || force_inst)) begin
      grant_i = 1'b1;
      owner   = OWN_INST;
    end else if (data_live) begin
      grant_d = 1'b1;
    end
  end

  // SRAM request side driven straight from the winner
  always_comb begin
    inst_addr_ok = grant_i;
    data_addr_ok = grant_d;
    mem_en       = grant_i | grant_d;
    mem_addr     = (owner == OWN_INST) ? inst_addr : data_addr;
    mem_we       = (grant_d && data_wr) ? data_wstrb : '0;
    mem_wdata    = grant_d ? data_wdata : '0;
  end

  // Consecutive denied inst cycles, saturating at the force threshold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || grant_i) begin
      starve_cnt <= '0;
    end else if (!force_inst) begin
      starve_cnt <= starve_cnt + STARVE_CNT_W'(1);
    end
  end

  cpu_arb_resp_tracker #(
    .DATA_W (DATA_W)
  ) u_resp_tracker (
    .clk          (clk),
    .resetn       (resetn),
    .grant_i      (grant_i),
    .grant_d      (grant_d),
    .grant_wr     (data_wr),
    .mem_rdata    (mem_rdata),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

`ifdef CPU_ARB_PERF_CNT_EN
  // Conflict, inst stall and forced-grant event counters (wrap at 2^32)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_conflict_cnt   <= '0;
      perf_inst_stall_cnt <= '0;
      perf_force_cnt      <= '0;
    end else begin
      if (inst_req && data_req) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
      if (inst_req && !grant_i) begin
        perf_inst_stall_cnt <= perf_inst_stall_cnt + 32'd1;
      end
      if (grant_i && data_live && force_inst) begin
        perf_force_cnt <= perf_force_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: per-cycle model comparison plus
// directed scenarios with hand-computed expectations.
module tb_cpu_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int          SMAX = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_en;
  logic [SW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef CPU_ARB_PERF_CNT_EN
  logic [31:0]   perf_conflict_cnt;
  logic [31:0]   perf_inst_stall_cnt;
  logic [31:0]   perf_force_cnt;
`endif

  always #5 clk = ~clk;

  cpu_mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .inst_req            (inst_req),
    .inst_addr           (inst_addr),
    .inst_addr_ok        (inst_addr_ok),
    .inst_data_ok        (inst_data_ok),
    .inst_rdata          (inst_rdata),
    .data_req            (data_req),
    .data_wr             (data_wr),
    .data_wstrb          (data_wstrb),
    .data_addr           (data_addr),
    .data_wdata          (data_wdata),
    .data_addr_ok        (data_addr_ok),
    .data_data_ok        (data_data_ok),
    .data_rdata          (data_rdata),
    .mem_rdata           (mem_rdata),
`ifdef CPU_ARB_PERF_CNT_EN
    .perf_conflict_cnt   (perf_conflict_cnt),
    .perf_inst_stall_cnt (perf_inst_stall_cnt),
    .perf_force_cnt      (perf_force_cnt),
`endif
    .mem_en              (mem_en),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Unwritten SRAM words read as address ^ A5A5A5A5
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return DW'(a) ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(SW); b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Environment: synchronous SRAM, read data valid the cycle after mem_en
  logic [DW-1:0] sram [logic [AW-1:0]];
  logic [DW-1:0] sram_cur;
  always @(posedge clk) begin
    if (mem_en) begin
      sram_cur = sram.exists(mem_addr) ? sram[mem_addr] : init_val(mem_addr);
      mem_rdata <= sram_cur;
      if (mem_we != '0) sram[mem_addr] = merge(sram_cur, mem_wdata, mem_we);
    end
  end

  // Reference model: transaction-level view of grants and responses
  typedef struct {
    bit            inst;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         pend_q[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  int            m_starve = 0;
  logic [31:0]   m_conf   = '0;
  logic [31:0]   m_stall  = '0;
  logic [31:0]   m_force  = '0;

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic void model_grant(output bit gi, output bit gd);
    gi = (resetn === 1'b1) && inst_req && (!data_req || m_starve == SMAX);
    gd = (resetn === 1'b1) && data_req && !gi;
  endfunction

  // Model update on each clock; reset drops any response owed
  always @(posedge clk or negedge resetn) begin : model_upd
    bit    gi, gd;
    resp_t r;
    if (!resetn) begin
      pend_q.delete();
      m_starve = 0;
      m_conf   = '0;
      m_stall  = '0;
      m_force  = '0;
    end else begin
      model_grant(gi, gd);
      pend_q.delete();
      if (gi) begin
        r.inst = 1'b1;
        r.data = shadow_rd(inst_addr);
        pend_q.push_back(r);
      end else if (gd) begin
        r.inst = 1'b0;
        r.data = data_wr ? '0 : shadow_rd(data_addr);
        if (data_wr) shadow[data_addr] = merge(shadow_rd(data_addr), data_wdata, data_wstrb);
        pend_q.push_back(r);
      end
      if (inst_req && !gi) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else m_starve = 0;
      if (inst_req && data_req) m_conf = m_conf + 32'd1;
      if (inst_req && !gi) m_stall = m_stall + 32'd1;
      if (gi && data_req) m_force = m_force + 32'd1;
    end
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin : cmp
    bit            gi, gd;
    bit            ri, rd;
    logic [DW-1:0] rdat;
    model_grant(gi, gd);
    ri   = (pend_q.size() > 0) && pend_q[0].inst;
    rd   = (pend_q.size() > 0) && !pend_q[0].inst;
    rdat = (pend_q.size() > 0) ? pend_q[0].data : '0;
    check("inst_addr_ok", 64'(inst_addr_ok), 64'(gi));
    check("data_addr_ok", 64'(data_addr_ok), 64'(gd));
    check("mem_en", 64'(mem_en), 64'(gi | gd));
    check("mem_we", 64'(mem_we), 64'((gd && data_wr) ? data_wstrb : '0));
    check("mem_wdata", 64'(mem_wdata), 64'(gd ? data_wdata : '0));
    if (gi | gd) check("mem_addr", 64'(mem_addr), 64'(gi ? inst_addr : data_addr));
    check("inst_data_ok", 64'(inst_data_ok), 64'(ri));
    check("inst_rdata", 64'(inst_rdata), 64'(ri ? rdat : '0));
    check("data_data_ok", 64'(data_data_ok), 64'(rd));
    check("data_rdata", 64'(data_rdata), 64'(rd ? rdat : '0));
`ifdef CPU_ARB_PERF_CNT_EN
    check("perf_conflict", 64'(perf_conflict_cnt), 64'(m_conf));
    check("perf_stall", 64'(perf_inst_stall_cnt), 64'(m_stall));
    check("perf_force", 64'(perf_force_cnt), 64'(m_force));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic req, input logic [AW-1:0] a);
    inst_req  = req;
    inst_addr = a;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [SW-1:0] strb,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd);
    data_req   = req;
    data_wr    = wr;
    data_wstrb = strb;
    data_addr  = a;
    data_wdata = wd;
  endtask

`ifdef CPU_ARB_PERF_CNT_EN
  logic [31:0] pc0, ps0, pf0;
`endif

  // Directed scenarios
  initial begin : stim
    logic [9:0] ok_pat;
    resetn = 1'b0;
    set_inst(1'b0, '0);
    set_data(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("rst_mem_en", 64'(mem_en), 64'(0));
    check("rst_data_data_ok", 64'(data_data_ok), 64'(0));
    @(posedge clk);
    #2 resetn = 1'b1;
    tick();

    // Fetch stream at 0x1C000000
    set_inst(1'b1, 32'h1C00_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_addr_ok", 64'(inst_addr_ok), 64'(1));
      check("t1_we", 64'(mem_we), 64'(0));
      if (i > 0) check("t1_rdata", 64'(inst_rdata), 64'(32'hB9A5_A5A5));
      tick();
    end
    set_inst(1'b0, '0);
    @(negedge clk);
    check("t1_last_ok", 64'(inst_data_ok), 64'(1));
    tick();

    // Partial store then readback
    set_data(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_we", 64'(mem_we), 64'(4'b0011));
    tick();
    set_data(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("t2_data_ok", 64'(data_data_ok), 64'(1));
    check("t2_rdata", 64'(data_rdata), 64'(0));
    tick();
    set_data(1'b1, 1'b0, '0, 32'h100, '0);
    tick();
    set_data(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("t2_readback", 64'(data_rdata), 64'(32'hA5A5_BEEF));
    tick();

    // Sustained conflict: inst forced on every fifth cycle
`ifdef CPU_ARB_PERF_CNT_EN
    pc0 = perf_conflict_cnt; ps0 = perf_inst_stall_cnt; pf0 = perf_force_cnt;
`endif
    set_inst(1'b1, 32'h1C00_0010);
    set_data(1'b1, 1'b0, '0, 32'h300, '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ok_pat[c] = inst_addr_ok;
      tick();
    end
    set_inst(1'b0, '0);
    set_data(1'b0, 1'b0, '0, '0, '0);
    check("t3_pattern", 64'(ok_pat), 64'(10'b10_0001_0000));
`ifdef CPU_ARB_PERF_CNT_EN
    check("t3_conf", 64'(perf_conflict_cnt - pc0), 64'(10));
    check("t3_stall", 64'(perf_inst_stall_cnt - ps0), 64'(8));
    check("t3_force", 64'(perf_force_cnt - pf0), 64'(2));
`endif
    tick();

    // Six conflict cycles from a cleared starvation count
`ifdef CPU_ARB_PERF_CNT_EN
    pc0 = perf_conflict_cnt; ps0 = perf_inst_stall_cnt; pf0 = perf_force_cnt;
`endif
    set_inst(1'b1, 32'h1C00_0020);
    set_data(1'b1, 1'b0, '0, 32'h340, '0);
    repeat (6) tick();
    set_inst(1'b0, '0);
    set_data(1'b0, 1'b0, '0, '0, '0);
`ifdef CPU_ARB_PERF_CNT_EN
    check("pf_conf", 64'(perf_conflict_cnt - pc0), 64'(6));
    check("pf_stall", 64'(perf_inst_stall_cnt - ps0), 64'(5));
    check("pf_force", 64'(perf_force_cnt - pf0), 64'(1));
`endif
    tick();

    // Load then fetch back-to-back; no response crossover
    set_data(1'b1, 1'b0, '0, 32'h200, '0);
    tick();
    set_data(1'b0, 1'b0, '0, '0, '0);
    set_inst(1'b1, 32'h0);
    @(negedge clk);
    check("t4_d_ok", 64'(data_data_ok), 64'(1));
    check("t4_d_rdata", 64'(data_rdata), 64'(32'hA5A5_A7A5));
    check("t4_i_quiet", 64'(inst_data_ok), 64'(0));
    tick();
    set_inst(1'b0, '0);
    @(negedge clk);
    check("t4_i_ok", 64'(inst_data_ok), 64'(1));
    check("t4_i_rdata", 64'(inst_rdata), 64'(32'hA5A5_A5A5));
    check("t4_d_quiet", 64'(data_data_ok), 64'(0));
    tick();

    // Async reset while a load response is due
    set_data(1'b1, 1'b0, '0, 32'h400, '0);
    tick();
    check("t5_pending", 64'(data_data_ok), 64'(1));
    resetn = 1'b0;
    #1;
    check("t5_rst_d_ok", 64'(data_data_ok), 64'(0));
    check("t5_rst_rdata", 64'(data_rdata), 64'(0));
    check("t5_rst_mem_en", 64'(mem_en), 64'(0));
    check("t5_rst_addr_ok", 64'(data_addr_ok), 64'(0));
    set_data(1'b0, 1'b0, '0, '0, '0);
    tick();
    @(posedge clk);
    #2 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_resp", 64'(data_data_ok), 64'(0));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
